// File: rtl/mult8x8_seq_ctrl.sv
// Sequencer forming an 8x8 product from four nibble partial products computed by one shared
// external 4x4 approximate multiplier, combined by exact add or OR, returned over valid/ready.
module mult8x8_seq_ctrl #(
  parameter bit COMBINE_OR = 1'b0,
  parameter int MUL_LAT    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [7:0]  cfg,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  output logic [1:0]  mul_sel,
  input  logic [7:0]  mul_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] R,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Capture of partial product k trails its issue by MUL_LAT cycles.
  localparam logic [2:0] CAP_START = 3'(MUL_LAT);

  logic [1:0]  state_q, state_d;
  logic [7:0]  a_q, a_d, b_q, b_d, cfg_q, cfg_d;
  logic [15:0] acc_q, acc_d, r_q, r_d;
  logic [2:0]  issue_cnt_q, issue_cnt_d;
  logic [1:0]  cap_cnt_q, cap_cnt_d;
  logic [3:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [1:0]  mul_sel_q, mul_sel_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] term;

  // Order k: 0 (Alo,Blo), 1 (Alo,Bhi), 2 (Ahi,Blo), 3 (Ahi,Bhi); variant from cfg[2k+1:2k].
  function automatic logic [9:0] pp_issue(input logic [1:0] k, input logic [7:0] a,
                                          input logic [7:0] b, input logic [7:0] c);
    logic [3:0] an, bn;
    an = k[1] ? a[7:4] : a[3:0];
    bn = k[0] ? b[7:4] : b[3:0];
    return {an, bn, c[{k, 1'b0} +: 2]};
  endfunction

  always_comb begin
    case (cap_cnt_q)
      2'd0:    term = {8'h00, mul_p};
      2'd3:    term = {mul_p, 8'h00};
      default: term = {4'h0, mul_p, 4'h0};
    endcase
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cfg_d       = cfg_q;
    acc_d       = acc_q;
    r_d         = r_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_sel_d   = mul_sel_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d         = A;
          b_d         = B;
          cfg_d       = cfg;
          acc_d       = 16'h0000;
          issue_cnt_d = 3'd0;
          cap_cnt_d   = 2'd0;
          // The first issue comes straight from the ports so pp0 is live in the first CALC cycle.
          {mul_a_d, mul_b_d, mul_sel_d} = pp_issue(2'd0, A, B, cfg);
          state_d     = S_CALC;
        end
      end
      S_CALC: begin
        if (issue_cnt_q < 3'd4) issue_cnt_d = issue_cnt_q + 3'd1;
        if (issue_cnt_q < 3'd3)
          {mul_a_d, mul_b_d, mul_sel_d} = pp_issue(issue_cnt_q[1:0] + 2'd1, a_q, b_q, cfg_q);
        if (issue_cnt_q >= CAP_START) begin
          acc_d     = COMBINE_OR ? (acc_q | term) : (acc_q + term);
          cap_cnt_d = cap_cnt_q + 2'd1;
          if (cap_cnt_q == 2'd3) begin
            r_d         = acc_d;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      cfg_q       <= 8'h00;
      acc_q       <= 16'h0000;
      r_q         <= 16'h0000;
      issue_cnt_q <= 3'd0;
      cap_cnt_q   <= 2'd0;
      mul_a_q     <= 4'h0;
      mul_b_q     <= 4'h0;
      mul_sel_q   <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cfg_q       <= cfg_d;
      acc_q       <= acc_d;
      r_q         <= r_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_sel_q   <= mul_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign R         = r_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_sel   = mul_sel_q;

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// Directed bench: three controllers (add/lat0, OR/lat0, add/lat1) driven by shared stimulus,
// each paired with an ideal exact 4x4 multiplier model.
module tb_mult8x8_seq_ctrl;

  logic       clk, rst_n, in_valid, out_ready;
  logic [7:0] A, B, cfg;

  logic        in_ready_e, out_valid_e, busy_e;
  logic [3:0]  mul_a_e, mul_b_e;
  logic [1:0]  mul_sel_e;
  logic [7:0]  mul_p_e;
  logic [15:0] r_e;

  logic        in_ready_o, out_valid_o, busy_o;
  logic [3:0]  mul_a_o, mul_b_o;
  logic [1:0]  mul_sel_o;
  logic [7:0]  mul_p_o;
  logic [15:0] r_o;

  logic        in_ready_l, out_valid_l, busy_l;
  logic [3:0]  mul_a_l, mul_b_l;
  logic [1:0]  mul_sel_l;
  logic [7:0]  mul_p_l;
  logic [15:0] r_l;

  int n_pass  = 0;
  int n_total = 0;

  mult8x8_seq_ctrl #(.COMBINE_OR(1'b0), .MUL_LAT(0)) dut_e (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_e), .A(A), .B(B), .cfg(cfg),
    .mul_a(mul_a_e), .mul_b(mul_b_e), .mul_sel(mul_sel_e), .mul_p(mul_p_e),
    .out_valid(out_valid_e), .out_ready(out_ready), .R(r_e), .busy(busy_e));

  mult8x8_seq_ctrl #(.COMBINE_OR(1'b1), .MUL_LAT(0)) dut_o (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o), .A(A), .B(B), .cfg(cfg),
    .mul_a(mul_a_o), .mul_b(mul_b_o), .mul_sel(mul_sel_o), .mul_p(mul_p_o),
    .out_valid(out_valid_o), .out_ready(out_ready), .R(r_o), .busy(busy_o));

  mult8x8_seq_ctrl #(.COMBINE_OR(1'b0), .MUL_LAT(1)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l), .A(A), .B(B), .cfg(cfg),
    .mul_a(mul_a_l), .mul_b(mul_b_l), .mul_sel(mul_sel_l), .mul_p(mul_p_l),
    .out_valid(out_valid_l), .out_ready(out_ready), .R(r_l), .busy(busy_l));

  assign mul_p_e = {4'h0, mul_a_e} * {4'h0, mul_b_e};
  assign mul_p_o = {4'h0, mul_a_o} * {4'h0, mul_b_o};
  always @(posedge clk) mul_p_l <= {4'h0, mul_a_l} * {4'h0, mul_b_l};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = 8'h00; B = 8'h00; cfg = 8'h00;
    #23 rst_n = 1'b1;
    step(1);
    check("rst_in_ready", in_ready_e, 1);
    check("rst_out_valid", out_valid_e, 0);
    check("rst_busy", busy_e, 0);
    check("rst_R", r_e, 0);
    check("rst_mul", {mul_a_e, mul_b_e, mul_sel_e}, 0);

    // T1/T6-style latency on FF*FF: lat0 after 4 edges, lat1 after 5.
    A = 8'hFF; B = 8'hFF; cfg = 8'h00; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    check("t1_busy", busy_e, 1);
    check("t1_in_ready", in_ready_e, 0);
    check("t1_mul0", {mul_a_e, mul_b_e}, 8'hFF);
    step(3);
    check("t1_valid_early", out_valid_e, 0);
    step(1);
    check("t1_valid", out_valid_e, 1);
    check("t1_R", r_e, 16'hFE01);
    check("t1_R_or", r_o, 16'hEFF1);
    check("t1_lat1_not_yet", out_valid_l, 0);
    step(1);
    check("t1_lat1_valid", out_valid_l, 1);
    check("t1_lat1_R", r_l, 16'hFE01);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("t1_drain_valid", out_valid_e, 0);
    check("t1_drain_ready", in_ready_e, 1);
    check("t1_R_retained", r_e, 16'hFE01);

    // T2 OR vs add combine, then T4 backpressure on the same job.
    A = 8'h11; B = 8'h11; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(4);
    check("t2_R_or", r_o, 16'h0111);
    check("t2_R_add", r_e, 16'h0121);
    A = 8'h77; B = 8'h99; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("t4_hold_valid", out_valid_e, 1);
      check("t4_hold_R", r_e, 16'h0121);
      check("t4_hold_in_ready", in_ready_e, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    check("t4_release_valid", out_valid_e, 0);
    check("t4_release_ready", in_ready_e, 1);
    step(1);
    check("t4_not_queued", busy_e, 0);

    // T3 variant and operand sequencing.
    A = 8'h9A; B = 8'h47; cfg = 8'b11_10_01_01; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    check("t3_pp0", {mul_a_e, mul_b_e, mul_sel_e}, {4'hA, 4'h7, 2'd1});
    step(1);
    check("t3_pp1", {mul_a_e, mul_b_e, mul_sel_e}, {4'hA, 4'h4, 2'd1});
    step(1);
    check("t3_pp2", {mul_a_e, mul_b_e, mul_sel_e}, {4'h9, 4'h7, 2'd2});
    step(1);
    check("t3_pp3", {mul_a_e, mul_b_e, mul_sel_e}, {4'h9, 4'h4, 2'd3});
    step(1);
    check("t3_pp3_held", {mul_a_e, mul_b_e, mul_sel_e}, {4'h9, 4'h4, 2'd3});
    check("t3_R", r_e, 16'h2AB6);
    out_ready = 1'b1;
    step(2);
    out_ready = 1'b0;
    check("t3_lat1_R", r_l, 16'h2AB6);

    // T5 reset during the second CALC cycle.
    A = 8'hFF; B = 8'hFF; cfg = 8'h00; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy_e, 0);
    check("t5_rst_ready", in_ready_e, 1);
    check("t5_rst_valid", out_valid_e, 0);
    check("t5_rst_R", r_l, 0);
    check("t5_rst_mul", {mul_a_e, mul_b_e, mul_sel_e}, 0);
    #1 rst_n = 1'b1;
    A = 8'd12; B = 8'd10; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(4);
    check("t5_valid", out_valid_e, 1);
    check("t5_R", r_e, 16'd120);
    out_ready = 1'b1;
    step(2);
    out_ready = 1'b0;

    // T6 registered 4x4 slice.
    A = 8'hA5; B = 8'h3C; in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(4);
    check("t6_lat0_R", r_e, 16'h26AC);
    check("t6_lat1_early", out_valid_l, 0);
    step(1);
    check("t6_lat1_valid", out_valid_l, 1);
    check("t6_lat1_R", r_l, 16'h26AC);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
